// File: rtl/tbuf_bus_arbiter.sv
// Round-robin owner selection and EN sequencing for a tristate bus with a forced all-off turnaround between owners.
// Grant from IDLE lands one edge after req is first seen; release is immediate; optional keeper output under TBUF_ARB_KEEPER_EN.
module tbuf_bus_arbiter #(
    parameter int N_REQ       = 4,
    parameter int TURN_CYCLES = 1,
    parameter int MAX_GRANT   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] en,
    output logic [N_REQ-1:0] grant,
    output logic             bus_idle,
    output logic             keeper_en
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int HW = (MAX_GRANT > 1) ? $clog2(MAX_GRANT) : 1;
    localparam int TW = $clog2(TURN_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'((MAX_GRANT > 0) ? MAX_GRANT - 1 : 0);
    localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYCLES - 1);
    localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_TURN} state_t;

    state_t           state;
    logic [PW-1:0]    owner;
    logic [PW-1:0]    ptr;
    logic [HW-1:0]    hold_cnt;
    logic [TW-1:0]    turn_cnt;
    logic             armed;
    logic [PW:0]      pick;
    logic             win_vld;
    logic [PW-1:0]    winner;
    logic [N_REQ-1:0] others;
    logic             preempt;
    logic             take;

    // Descending scan so the requester closest to ptr is the last to overwrite.
    function automatic logic [PW:0] rr_pick(input logic [N_REQ-1:0] r, input logic [PW-1:0] p);
        logic [PW:0] res;
        logic [PW:0] idx;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, p} + (PW+1)'(i);
            if (idx >= (PW+1)'(N_REQ)) begin
                idx = idx - (PW+1)'(N_REQ);
            end
            if (r[idx[PW-1:0]]) begin
                res = {1'b1, idx[PW-1:0]};
            end
        end
        return res;
    endfunction

    always_comb begin
        pick    = rr_pick(req, ptr);
        win_vld = pick[PW];
        winner  = pick[PW-1:0];
        others  = req & ~(ONE << owner);
        preempt = (MAX_GRANT != 0) && (hold_cnt == HOLD_MAX) && (|others);
        take    = win_vld && (((state == ST_IDLE) && armed) ||
                              ((state == ST_TURN) && (turn_cnt == TURN_LAST)));
    end

    assign grant = en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            en       <= '0;
            owner    <= '0;
            ptr      <= '0;
            hold_cnt <= '0;
            turn_cnt <= '0;
            armed    <= 1'b0;
            bus_idle <= 1'b1;
        end else if (take) begin
            state    <= ST_OWN;
            en       <= ONE << winner;
            owner    <= winner;
            ptr      <= (winner == PW'(N_REQ - 1)) ? '0 : winner + 1'b1;
            hold_cnt <= '0;
            armed    <= 1'b0;
            bus_idle <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    armed <= |req;
                end
                ST_OWN: begin
                    if (!req[owner] || preempt) begin
                        state    <= ST_TURN;
                        en       <= '0;
                        turn_cnt <= '0;
                    end else if (hold_cnt != HOLD_MAX) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                ST_TURN: begin
                    if (turn_cnt == TURN_LAST) begin
                        state    <= ST_IDLE;
                        bus_idle <= 1'b1;
                        armed    <= 1'b0;
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    en       <= '0;
                    bus_idle <= 1'b1;
                end
            endcase
        end
    end

`ifdef TBUF_ARB_KEEPER_EN
    // Keeper engages only once every driver has been off for at least one full cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            keeper_en <= 1'b1;
        end else begin
            keeper_en <= (state != ST_OWN) && !take;
        end
    end
`else
    assign keeper_en = 1'b0;
`endif

endmodule

// File: tb/tb_tbuf_bus_arbiter.sv
// Randomised and directed bench for tbuf_bus_arbiter against a behavioural bus-ownership model.
module tb_tbuf_bus_arbiter;

    localparam int N  = 4;
    localparam int TC = 2;
    localparam int MG = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic [N-1:0] en;
    logic [N-1:0] grant;
    logic         bus_idle;
    logic         keeper_en;

    int checks   = 0;
    int failures = 0;

    // Model state: mode 0 = bus floating, 1 = someone owns it, 2 = turnaround.
    int  m_mode  = 0;
    int  m_owner = 0;
    int  m_ptr   = 0;
    int  m_held  = 0;
    int  m_off   = 0;
    bit  m_seen  = 1'b0;

    logic [N-1:0] last_en  = '0;
    int           zero_run = 0;

    tbuf_bus_arbiter #(.N_REQ(N), .TURN_CYCLES(TC), .MAX_GRANT(MG)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .en        (en),
        .grant     (grant),
        .bus_idle  (bus_idle),
        .keeper_en (keeper_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_choice(input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic give_bus(input int w);
        m_mode  = 1;
        m_owner = w;
        m_ptr   = (w + 1) % N;
        m_held  = 0;
        m_seen  = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic rs);
        int w;
        if (rs) begin
            m_mode = 0; m_ptr = 0; m_seen = 1'b0;
            return;
        end
        w = rr_choice(r);
        case (m_mode)
            0: begin
                if (m_seen && w >= 0) give_bus(w);
                else m_seen = (r != 0);
            end
            1: begin
                m_held++;
                if (!r[m_owner]) begin
                    m_mode = 2; m_off = 0;
                end else if (MG != 0 && m_held >= MG && (r & ~(N'(1) << m_owner)) != 0) begin
                    m_mode = 2; m_off = 0;
                end
            end
            default: begin
                if (m_off + 1 >= TC) begin
                    if (w >= 0) give_bus(w);
                    else begin m_mode = 0; m_seen = 1'b0; end
                end else begin
                    m_off++;
                end
            end
        endcase
    endtask

    task automatic compare(input logic rs);
        logic [N-1:0] e;
        e = '0;
        if (m_mode == 1) e[m_owner] = 1'b1;
        chk("en", 32'(en), 32'(e));
        chk("grant", 32'(grant), 32'(e));
        chk("bus_idle", 32'(bus_idle), 32'(m_mode == 0));
`ifdef TBUF_ARB_KEEPER_EN
        chk("keeper_en", 32'(keeper_en), 32'((m_mode == 0) || (m_mode == 2 && m_off > 0)));
        chk("keeper_excl", 32'(keeper_en & (|en)), 32'(0));
`else
        chk("keeper_off", 32'(keeper_en), 32'(0));
`endif
        chk("onehot0", 32'($countones(en) <= 1), 32'(1));
        if (rs) begin
            last_en = '0; zero_run = 0;
        end else if (en != 0) begin
            if (last_en != 0 && en != last_en) chk("turn_gap", 32'(zero_run >= TC), 32'(1));
            last_en = en; zero_run = 0;
        end else begin
            zero_run++;
        end
    endtask

    task automatic cycle(input logic [N-1:0] r, input logic rs);
        @(negedge clk);
        req = r;
        rst = rs;
        @(posedge clk);
        model_step(r, rs);
        #1;
        compare(rs);
    endtask

    initial begin
        logic [N-1:0] r;

        cycle(4'b1111, 1'b1);
        cycle(4'b1111, 1'b1);
        chk("reset_en", 32'(en), 32'(0));
        chk("reset_idle", 32'(bus_idle), 32'(1));
        cycle(4'b1111, 1'b0);
        cycle(4'b1111, 1'b0);
        chk("first_grant", 32'(en), 32'(4'b0001));

        repeat (6) cycle(4'b0000, 1'b0);
        cycle(4'b0100, 1'b0);
        cycle(4'b0100, 1'b0);
        chk("single_grant", 32'(en), 32'(4'b0100));
        repeat (8) cycle(4'b0100, 1'b0);
        cycle(4'b0000, 1'b0);
        chk("single_release", 32'(en), 32'(0));
        repeat (TC) cycle(4'b0000, 1'b0);
        chk("single_idle", 32'(bus_idle), 32'(1));

        repeat (80) cycle(4'b1111, 1'b0);
        repeat (6) cycle(4'b0000, 1'b0);

        cycle(4'b0010, 1'b0);
        for (int i = 0; i < 50; i++) begin
            cycle(4'b0010, 1'b0);
            chk("lone_owner", 32'(en), 32'(4'b0010));
        end

        repeat (6) cycle(4'b0000, 1'b0);
        repeat (4) cycle(4'b1000, 1'b0);
        chk("pre_reset_owner", 32'(en), 32'(4'b1000));
        cycle(4'b1000, 1'b1);
        chk("mid_reset_en", 32'(en), 32'(0));
        cycle(4'b1001, 1'b0);
        cycle(4'b1001, 1'b0);
        chk("post_reset_ptr", 32'(en), 32'(4'b0001));

        r = '0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
            cycle(r, ($urandom_range(0, 499) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
